ysyx_22040237_mdu: RTL and testbench

// Parametrised multi-cycle multiply/divide unit (RV M-extension, incl. W variants) beside the

---
 rtl/ysyx_22040237_mdu.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_ysyx_22040237_mdu.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040237_mdu.sv
// ----------------------------------------------------------------------------
// ysyx_22040237_mdu
// Multi-cycle multiply/divide unit for the RV64 M extension, W variants included.
// It sits beside the single-cycle ALU in the execute stage.
// It takes one request over a valid/ready handshake and computes the result
// iteratively: shift-add for multiply, restoring division for divide. It returns
// the result and the rd index over a second valid/ready handshake. A flush aborts
// any operation in progress.
//
// Parameters
//   XLEN  datapath width (32 or 64)
//   STEP  product/quotient bits resolved per CALC cycle (1 or 2)
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   req_valid_i    request valid
//   req_ready_o    unit can accept (IDLE and no flush)
//   req_op_i       funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   req_word_i     W variant: 32-bit operands, result sign-extended from bit 31
//   req_rd_idx_i   destination register index
//   req_src1_i     rs1 / multiplicand / dividend
//   req_src2_i     rs2 / multiplier / divisor
//   flush_i        abort in-flight op and drop any pending result
//   rsp_valid_o    result valid
//   rsp_ready_i    consumer accepts result
//   rsp_rd_idx_o   rd of completed op
//   rsp_res_o      result
//   busy_o         unit not idle
//
// Optional feature macro: YSYX_22040237_MDU_FAST_MUL_EN
//   When defined, every multiply uses a single-cycle XLEN x XLEN multiplier that
//   is captured at accept. The operation skips CALC and takes 2 cycles.
// ----------------------------------------------------------------------------
module ysyx_22040237_mdu #(
    parameter int XLEN = 64,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic            req_word_i,
    input  logic [4:0]      req_rd_idx_i,
    input  logic [XLEN-1:0] req_src1_i,
    input  logic [XLEN-1:0] req_src2_i,
    input  logic            flush_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [4:0]      rsp_rd_idx_o,
    output logic [XLEN-1:0] rsp_res_o,
    output logic            busy_o
);

    localparam int NFULL = XLEN / STEP;
    localparam int NWORD = 32 / STEP;
    localparam int CW    = $clog2(NFULL);
    localparam logic [CW-1:0] LAST_FULL = CW'(NFULL - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(NWORD - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [2:0]      op;
    logic            word;
    logic [4:0]      rd;
    logic            neg;
    // Multiply: acc = running high half, shreg = multiplier / low half.
    // Divide:   acc = partial remainder,  shreg = dividend / quotient.
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] shreg;
    logic [XLEN-1:0] opnd;

    logic            accept;
    logic            is_div;
    logic            word_mul;
    logic            signed1;
    logic            signed2;
    logic [XLEN-1:0] ext1;
    logic [XLEN-1:0] ext2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN-1:0] min_val;
    logic            sign1;
    logic            sign2;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic            fast_mul;

`ifdef YSYX_22040237_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    // Request decode. W multiplies only need the low 32 product bits, and those
    // bits do not depend on signedness, so W multiplies run unsigned on
    // zero-extended operands.
    always_comb begin
        is_div   = req_op_i[2];
        word_mul = req_word_i && !is_div;
        signed1  = !word_mul && (req_op_i == 3'd1 || req_op_i == 3'd2 ||
                                 req_op_i == 3'd4 || req_op_i == 3'd6);
        signed2  = !word_mul && (req_op_i == 3'd1 || req_op_i == 3'd4 ||
                                 req_op_i == 3'd6);
        if (req_word_i) begin
            ext1    = signed1 ? XLEN'($signed(req_src1_i[31:0])) : XLEN'(req_src1_i[31:0]);
            ext2    = signed2 ? XLEN'($signed(req_src2_i[31:0])) : XLEN'(req_src2_i[31:0]);
            min_val = XLEN'($signed(32'h8000_0000));
        end else begin
            ext1    = req_src1_i;
            ext2    = req_src2_i;
            min_val = {1'b1, {(XLEN-1){1'b0}}};
        end
        sign1    = signed1 && ext1[XLEN-1];
        sign2    = signed2 && ext2[XLEN-1];
        mag1     = sign1 ? -ext1 : ext1;
        mag2     = sign2 ? -ext2 : ext2;
        div_zero = is_div && (ext2 == '0);
        div_ovf  = is_div && !req_op_i[0] && (ext1 == min_val) && (ext2 == '1);
        special  = div_zero || div_ovf;
`ifdef YSYX_22040237_MDU_FAST_MUL_EN
        fast_mul  = !is_div;
        // Shift W products up so they sit where the iterative path leaves them.
        fast_prod = ({{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2}) << (req_word_i ? (XLEN - 32) : 0);
`else
        fast_mul  = 1'b0;
`endif
        accept   = req_valid_i && req_ready_o;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic. Flush overrides everything, including a response
    // handshake in DONE.
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (req_valid_i) state_next = (special || fast_mul) ? FIX : CALC;
                CALC: if (count == (word ? LAST_WORD : LAST_FULL)) state_next = FIX;
                FIX:  state_next = DONE;
                DONE: if (rsp_ready_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        req_ready_o = (state == IDLE) && !flush_i;
        rsp_valid_o = (state == DONE);
        busy_o      = (state != IDLE);
    end

    // One CALC cycle: STEP rounds of restoring division or shift-add multiplication.
    logic [XLEN-1:0] acc_step;
    logic [XLEN-1:0] shreg_step;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic            fits;

    always_comb begin
        acc_step   = acc;
        shreg_step = shreg;
        sum        = '0;
        shifted    = '0;
        fits       = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (op[2]) begin
                shifted    = {acc_step, shreg_step[XLEN-1]};
                fits       = shifted >= {1'b0, opnd};
                acc_step   = fits ? (shifted[XLEN-1:0] - opnd) : shifted[XLEN-1:0];
                shreg_step = {shreg_step[XLEN-2:0], fits};
            end else begin
                sum        = {1'b0, acc_step} + (shreg_step[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
                acc_step   = sum[XLEN:1];
                shreg_step = {sum[0], shreg_step[XLEN-1:1]};
            end
        end
    end

    // FIX-stage result: apply the recorded sign, select the result half, and
    // sign-extend W results.
    logic [2*XLEN-1:0] prod_full;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo_res;
    logic [XLEN-1:0]   rem_res;
    logic [XLEN-1:0]   fix_raw;
    logic [XLEN-1:0]   fix_res;

    always_comb begin
        prod_full   = {acc, shreg};
        prod_signed = neg ? -prod_full : prod_full;
        quo_res     = neg ? -shreg : shreg;
        rem_res     = neg ? -acc : acc;
        if (op[2]) begin
            fix_raw = op[1] ? rem_res : quo_res;
        end else if (op[1:0] == 2'd0) begin
            fix_raw = prod_signed[XLEN-1:0];
        end else begin
            fix_raw = prod_signed[2*XLEN-1:XLEN];
        end
        if (word && !op[2]) begin
            fix_res = XLEN'($signed(shreg[XLEN-1 -: 32]));
        end else if (word) begin
            fix_res = XLEN'($signed(fix_raw[31:0]));
        end else begin
            fix_res = fix_raw;
        end
    end

    // Datapath registers. Divide special cases load the final quotient and
    // remainder at accept and clear the sign, so FIX passes them through
    // unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count        <= '0;
            op           <= '0;
            word         <= 1'b0;
            rd           <= '0;
            neg          <= 1'b0;
            acc          <= '0;
            shreg        <= '0;
            opnd         <= '0;
            rsp_res_o    <= '0;
            rsp_rd_idx_o <= '0;
        end else if (flush_i) begin
            count <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op    <= req_op_i;
                    word  <= req_word_i;
                    rd    <= req_rd_idx_i;
                    count <= '0;
                    if (is_div) begin
                        opnd <= mag2;
                        if (div_zero) begin
                            shreg <= '1;
                            acc   <= ext1;
                            neg   <= 1'b0;
                        end else if (div_ovf) begin
                            shreg <= ext1;
                            acc   <= '0;
                            neg   <= 1'b0;
                        end else begin
                            shreg <= mag1 << (req_word_i ? (XLEN - 32) : 0);
                            acc   <= '0;
                            neg   <= req_op_i[1] ? sign1 : (sign1 ^ sign2);
                        end
                    end else begin
                        opnd <= mag1;
                        neg  <= sign1 ^ sign2;
`ifdef YSYX_22040237_MDU_FAST_MUL_EN
                        acc   <= fast_prod[2*XLEN-1:XLEN];
                        shreg <= fast_prod[XLEN-1:0];
`else
                        acc   <= '0;
                        shreg <= mag2;
`endif
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    shreg <= shreg_step;
                    count <= count + CW'(1);
                end
                FIX: begin
                    rsp_res_o    <= fix_res;
                    rsp_rd_idx_o <= rd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040237_mdu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040237_mdu
// Self-checking bench for ysyx_22040237_mdu with XLEN=64 and STEP=1.
// The driver pushes the expected response for each accepted request into a
// scoreboard queue. A monitor process then checks the result, rd, and latency
// whenever the DUT presents a response.
// ----------------------------------------------------------------------------
module tb_ysyx_22040237_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_word;
    logic [4:0]  req_rd;
    logic [63:0] req_src1;
    logic [63:0] req_src2;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_rd;
    logic [63:0] rsp_res;
    logic        busy;

    ysyx_22040237_mdu #(.XLEN(64), .STEP(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_word_i   (req_word),
        .req_rd_idx_i (req_rd),
        .req_src1_i   (req_src1),
        .req_src2_i   (req_src2),
        .flush_i      (flush),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rd_idx_o (rsp_rd),
        .rsp_res_o    (rsp_res),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          accept_cycle;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    logic hold_ready = 1'b0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: bound expired", name);
    endfunction

    // Reference model written from the M-extension rules using plain arithmetic.
    function automatic void model(input logic [2:0] op, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] res, output int lat);
        logic signed [129:0] pa;
        logic signed [129:0] pb;
        logic signed [129:0] pp;
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] r32;
        logic        sp;
        a32 = a[31:0];
        b32 = b[31:0];
        r32 = '0;
        sp  = 1'b0;
        res = '0;
        pa  = '0;
        pb  = '0;
        pp  = '0;
        if (w) begin
            case (op)
                3'd4: if (b32 == 0) begin r32 = '1; sp = 1'b1; end
                      else if (a32 == 32'h8000_0000 && b32 == '1) begin r32 = a32; sp = 1'b1; end
                      else r32 = $signed(a32) / $signed(b32);
                3'd5: if (b32 == 0) begin r32 = '1; sp = 1'b1; end
                      else r32 = a32 / b32;
                3'd6: if (b32 == 0) begin r32 = a32; sp = 1'b1; end
                      else if (a32 == 32'h8000_0000 && b32 == '1) begin r32 = '0; sp = 1'b1; end
                      else r32 = $signed(a32) % $signed(b32);
                3'd7: if (b32 == 0) begin r32 = a32; sp = 1'b1; end
                      else r32 = a32 % b32;
                default: r32 = a32 * b32;
            endcase
            res = {{32{r32[31]}}, r32};
            lat = sp ? 2 : 34;
        end else begin
            case (op)
                3'd4: if (b == 0) begin res = '1; sp = 1'b1; end
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) begin res = a; sp = 1'b1; end
                      else res = $signed(a) / $signed(b);
                3'd5: if (b == 0) begin res = '1; sp = 1'b1; end
                      else res = a / b;
                3'd6: if (b == 0) begin res = a; sp = 1'b1; end
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) begin res = '0; sp = 1'b1; end
                      else res = $signed(a) % $signed(b);
                3'd7: if (b == 0) begin res = a; sp = 1'b1; end
                      else res = a % b;
                default: begin
                    pa  = (op == 3'd1 || op == 3'd2) ? {{66{a[63]}}, a} : {66'd0, a};
                    pb  = (op == 3'd1) ? {{66{b[63]}}, b} : {66'd0, b};
                    pp  = pa * pb;
                    res = (op == 3'd0) ? pp[63:0] : pp[127:64];
                end
            endcase
            lat = sp ? 2 : 66;
        end
`ifdef YSYX_22040237_MDU_FAST_MUL_EN
        if (!op[2]) lat = 2;
`endif
    endfunction

    function automatic logic [63:0] pick_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'hFFFF_FFFF_8000_0000;
            4: v = 64'($signed($urandom_range(0, 16)) - 8);
            5: v = {32'd0, 32'($urandom)};
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    // Drive one request, hold it until accepted, and record its expected response.
    task automatic apply_stimulus(input logic [2:0] op, input logic w, input logic [4:0] rd,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] exp_res, input int exp_lat);
        int   waited;
        exp_t e;
        waited = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_word  = w;
        req_rd    = rd;
        req_src1  = a;
        req_src2  = b;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 400) begin
                fail_now("accept_timeout");
                req_valid = 1'b0;
                return;
            end
        end
        e.res          = exp_res;
        e.rd           = rd;
        e.accept_cycle = cycle + 1;
        e.lat          = exp_lat;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic apply_random(input logic [2:0] op, input logic w, input logic [4:0] rd,
                                input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        int          l;
        model(op, w, a, b, r, l);
        apply_stimulus(op, w, rd, a, b, r, l);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb_q.size() != 0) begin
            @(negedge clk);
            waited++;
            if (waited > 600) begin
                fail_now("drain_timeout");
                sb_q.delete();
            end
        end
        @(negedge clk);
    endtask

    // Consumer-side ready: random backpressure unless held low.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks each presented response against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && !flush && rsp_valid) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_rsp: got rd=%0d res=0x%h expected no response", rsp_rd, rsp_res);
                end else begin
                    if (!prev_valid)
                        check_output("latency", 64'(cycle - sb_q[0].accept_cycle + 1), 64'(sb_q[0].lat));
                    check_output("result", rsp_res, sb_q[0].res);
                    check_output("rd_idx", 64'(rsp_rd), 64'(sb_q[0].rd));
                    check_output("req_ready_in_done", 64'(req_ready), 64'd0);
                    if (rsp_ready) void'(sb_q.pop_front());
                end
            end
            prev_valid = rst && !flush && rsp_valid;
        end
    end

    initial begin
        int waited;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_word  = 1'b0;
        req_rd    = '0;
        req_src1  = '0;
        req_src2  = '0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_valid", 64'(rsp_valid), 64'd0);
        check_output("reset_res", rsp_res, 64'd0);
        check_output("reset_rd", 64'(rsp_rd), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] directed cases");
        apply_stimulus(3'd0, 1'b0, 5'd1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 66);
        apply_stimulus(3'd4, 1'b0, 5'd2, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        apply_stimulus(3'd7, 1'b0, 5'd3, 64'd7, 64'd0, 64'd7, 2);
        apply_stimulus(3'd4, 1'b0, 5'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2);
        apply_stimulus(3'd6, 1'b0, 5'd5, 64'h8000_0000_0000_0000, '1, 64'd0, 2);
        apply_stimulus(3'd3, 1'b0, 5'd6, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        apply_stimulus(3'd2, 1'b0, 5'd7, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        apply_stimulus(3'd4, 1'b1, 5'd8, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        apply_stimulus(3'd6, 1'b1, 5'd9, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        drain();

        $display("[TB] response held in DONE");
        hold_ready = 1'b1;
        apply_random(3'd5, 1'b0, 5'd10, 64'd100, 64'd7);
        waited = 0;
        while (!rsp_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!rsp_valid) fail_now("hold_wait_valid");
        repeat (5) @(negedge clk);
        hold_ready = 1'b0;
        drain();

        $display("[TB] flush during CALC");
        apply_random(3'd4, 1'b0, 5'd11, 64'd12345, 64'd17);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        check_output("flush_busy", 64'(busy), 64'd0);
        check_output("flush_valid", 64'(rsp_valid), 64'd0);
        repeat (80) @(negedge clk);
        apply_random(3'd1, 1'b0, 5'd12, 64'hDEAD_BEEF_1234_5678, 64'hF000_0000_0000_0001);
        drain();

        $display("[TB] flush with request in same cycle");
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 3'd5;
        req_word  = 1'b0;
        req_src1  = 64'd9;
        req_src2  = 64'd3;
        flush     = 1'b1;
        @(negedge clk);
        check_output("flush_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        check_output("flush_req_busy", 64'(busy), 64'd0);
        req_valid = 1'b0;
        flush     = 1'b0;

        $display("[TB] async reset mid operation");
        apply_random(3'd0, 1'b0, 5'd13, 64'h1234, 64'h5678);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_valid", 64'(rsp_valid), 64'd0);
        check_output("rst_res", rsp_res, 64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;

        $display("[TB] random operations");
        for (int i = 0; i < 150; i++) begin
            apply_random(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                         5'($urandom), pick_operand(), pick_operand());
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
